// File: rtl/dcp_pkg.sv
// Shared definitions for the DCP command blocks: command codes, ASCII
// constants, print-type encodings and the memory-dump state enum.
package dcp_pkg;

  localparam logic [7:0] DCP_CMD_D = 8'h44;
  localparam logic [7:0] DCP_CMD_I = 8'h49;

  localparam logic [7:0] ASCII_SEP = 8'h2D;
  localparam logic [7:0] ASCII_NL  = 8'h0A;

  localparam logic TYPE_CHAR = 1'b0;
  localparam logic TYPE_HEX  = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARG_A,
    S_ARG_N,
    S_FETCH,
    S_P_ADDR,
    S_P_SEP,
    S_P_DATA,
    S_P_NL,
    S_DONE
  } state_t;

endpackage

// File: rtl/dcp_hs_req.sv
// Request holder for the scan/print handshakes: raises req while enabled and
// keeps it until the matching ack.
module dcp_hs_req (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic ack,
  output logic req,
  output logic done
);

  // Handshake: a transfer completes on a cycle with req && ack; req then drops
  // for at least one cycle. An ack while req is low is ignored.
  assign done = req & ack;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req <= 1'b0;
    end else if (!en || done) begin
      req <= 1'b0;
    end else begin
      req <= 1'b1;
    end
  end

endmodule

// File: rtl/dcp_mem_dump.sv
// DCP 'D'/'I' command: scans an optional start address and word count, then
// prints "addr-data\n" for each word of data or instruction memory.
module dcp_mem_dump
  import dcp_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int          DUMP_WORDS = 8,
  parameter int          ADDR_STEP  = 1,
  parameter logic [7:0]  CMD_D      = DCP_CMD_D,
  parameter logic [7:0]  CMD_I      = DCP_CMD_I
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        sel_mode,
  input  logic [31:0]       din_rx,
  input  logic              ack_rx,
  input  logic              flag_rx,
  input  logic              ack_tx,
  input  logic [DATA_W-1:0] dout_dm,
  input  logic [DATA_W-1:0] dout_im,
  output logic              req_rx,
  output logic              type_rx,
  output logic              req_tx,
  output logic              type_tx,
  output logic [31:0]       dout_tx,
  output logic [ADDR_W-1:0] addr,
  output logic              finish
);

  state_t            state, state_nxt;
  logic              tgt_im;
  logic              sel_d, sel_i, active, abort;
  logic              is_arg, is_print;
  logic              rx_en, tx_en, rx_done, tx_done;
  logic [ADDR_W-1:0] addr_q, addr_inc, next_d, next_i, saved;
  logic [7:0]        count;
  logic [DATA_W-1:0] data_q;
  logic              save_en;
  logic [ADDR_W-1:0] save_val;

  assign sel_d    = (sel_mode == CMD_D);
  assign sel_i    = (sel_mode == CMD_I);
  assign active   = tgt_im ? sel_i : sel_d;
  assign is_arg   = (state == S_ARG_A) || (state == S_ARG_N);
  assign is_print = (state == S_P_ADDR) || (state == S_P_SEP) ||
                    (state == S_P_DATA) || (state == S_P_NL);
  assign abort    = !active && (state != S_IDLE) && (state != S_DONE);
  assign rx_en    = is_arg & active;
  assign tx_en    = is_print & active;
  assign addr_inc = addr_q + ADDR_W'(ADDR_STEP);
  assign saved    = tgt_im ? next_i : next_d;
  assign addr     = addr_q;

  dcp_hs_req u_rx_req (
    .clk  (clk),
    .rstn (rstn),
    .en   (rx_en),
    .ack  (ack_rx),
    .req  (req_rx),
    .done (rx_done)
  );

  dcp_hs_req u_tx_req (
    .clk  (clk),
    .rstn (rstn),
    .en   (tx_en),
    .ack  (ack_tx),
    .req  (req_tx),
    .done (tx_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (sel_d || sel_i) state_nxt = S_ARG_A;
        S_ARG_A:  if (rx_done) state_nxt = flag_rx ? S_ARG_N : S_FETCH;
        S_ARG_N:  if (rx_done) state_nxt = S_FETCH;
        S_FETCH:  state_nxt = S_P_ADDR;
        S_P_ADDR: if (tx_done) state_nxt = S_P_SEP;
        S_P_SEP:  if (tx_done) state_nxt = S_P_DATA;
        S_P_DATA: if (tx_done) state_nxt = S_P_NL;
        S_P_NL:   if (tx_done) state_nxt = (count == 8'd1) ? S_DONE : S_FETCH;
        S_DONE:   if (!active) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    type_rx = is_arg;
    type_tx = TYPE_CHAR;
    dout_tx = '0;
    finish  = (state == S_DONE);
    case (state)
      S_P_ADDR: begin
        type_tx = TYPE_HEX;
        dout_tx = 32'(addr_q);
      end
      S_P_SEP:  dout_tx = 32'(ASCII_SEP);
      S_P_DATA: begin
        type_tx = TYPE_HEX;
        dout_tx = 32'(data_q);
      end
      S_P_NL:   dout_tx = 32'(ASCII_NL);
      default:  ;
    endcase
  end

  // An aborted dump resumes at the first word not yet fully printed.
  always_comb begin
    save_en  = 1'b0;
    save_val = addr_q;
    if (abort && state != S_ARG_A) begin
      save_en = 1'b1;
    end else if (state == S_P_NL && tx_done && count == 8'd1) begin
      save_en  = 1'b1;
      save_val = addr_inc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tgt_im <= 1'b0;
      addr_q <= '0;
      next_d <= '0;
      next_i <= '0;
      count  <= '0;
      data_q <= '0;
    end else begin
      if (state == S_IDLE && (sel_d || sel_i)) tgt_im <= !sel_d;
      if (save_en) begin
        if (tgt_im) next_i <= save_val;
        else        next_d <= save_val;
      end
      if (!abort) begin
        case (state)
          S_ARG_A: if (rx_done) begin
            if (flag_rx) begin
              addr_q <= ADDR_W'(din_rx);
            end else begin
              addr_q <= saved;
              count  <= 8'(DUMP_WORDS);
            end
          end
          S_ARG_N: if (rx_done) begin
            count <= (flag_rx && din_rx[7:0] != 8'd0) ? din_rx[7:0] : 8'(DUMP_WORDS);
          end
          S_FETCH: data_q <= tgt_im ? dout_im : dout_dm;
          S_P_NL: if (tx_done) begin
            addr_q <= addr_inc;
            count  <= count - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcp_mem_dump.sv
// Bench for dcp_mem_dump (ADDR_W=8): a command-level model builds the expected
// print stream, and a per-cycle compare process checks prints and handshakes.
module tb_dcp_mem_dump;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rstn;
  logic [7:0]        sel_mode;
  logic [31:0]       din_rx;
  logic              ack_rx, flag_rx, ack_tx;
  logic [DATA_W-1:0] dout_dm, dout_im;
  logic              req_rx, type_rx, req_tx, type_tx, finish;
  logic [31:0]       dout_tx;
  logic [ADDR_W-1:0] addr;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] exp_q[$];
  logic [32:0] rx_q[$];
  logic [7:0]  mdl_next [2];
  int          tx_delay = 0;
  bit          spur_rx = 0;

  dcp_mem_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sel_mode (sel_mode),
    .din_rx   (din_rx),
    .ack_rx   (ack_rx),
    .flag_rx  (flag_rx),
    .ack_tx   (ack_tx),
    .dout_dm  (dout_dm),
    .dout_im  (dout_im),
    .req_rx   (req_rx),
    .type_rx  (type_rx),
    .req_tx   (req_tx),
    .type_tx  (type_tx),
    .dout_tx  (dout_tx),
    .addr     (addr),
    .finish   (finish)
  );

  // Memories: combinational reads with address-derived contents.
  assign dout_dm = 32'(addr) + 32'h100;
  assign dout_im = 32'(addr) + 32'h200;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] hx(input logic [31:0] v);
    return {1'b1, v};
  endfunction

  function automatic logic [32:0] ch(input logic [31:0] v);
    return {1'b0, v};
  endfunction

  // Command-level model: expected print tokens for one dump command.
  task automatic model_cmd(input bit im, input bit has_a, input logic [31:0] a,
                           input bit has_n, input logic [31:0] n);
    logic [7:0] ad;
    int         cnt;
    ad  = has_a ? a[7:0] : mdl_next[im];
    cnt = (has_a && has_n && n[7:0] != 8'd0) ? int'(n[7:0]) : 8;
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back(hx(32'(ad)));
      exp_q.push_back(ch(32'h2D));
      exp_q.push_back(hx(32'(ad) + (im ? 32'h200 : 32'h100)));
      exp_q.push_back(ch(32'h0A));
      ad = ad + 8'd1;
    end
    mdl_next[im] = ad;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input bit im, input bit has_a, input logic [31:0] a,
                           input bit has_n, input logic [31:0] n);
    model_cmd(im, has_a, a, has_n, n);
    if (has_a) begin
      rx_q.push_back({1'b1, a});
      rx_q.push_back({has_n, n});
    end else begin
      rx_q.push_back({1'b0, 32'h0});
    end
    @(posedge clk); #1;
    sel_mode = im ? 8'h49 : 8'h44;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (finish !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({name, " finish"}, 33'(finish), 33'd1);
    check({name, " drained"}, 33'(exp_q.size()), 33'd0);
    @(posedge clk); #1;
    sel_mode = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check({name, " finish clear"}, 33'(finish), 33'd0);
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic wait_print(input string name, input logic [32:0] pat);
    int k;
    k = 0;
    @(negedge clk);
    while (!(req_tx === 1'b1 && {type_tx, dout_tx} === pat) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({name, " reached"}, {type_tx, dout_tx}, pat);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " req_rx"},  33'(req_rx),  33'd0);
    check({name, " type_rx"}, 33'(type_rx), 33'd0);
    check({name, " req_tx"},  33'(req_tx),  33'd0);
    check({name, " type_tx"}, 33'(type_tx), 33'd0);
    check({name, " finish"},  33'(finish),  33'd0);
    check({name, " dout_tx"}, 33'(dout_tx), 33'd0);
    check({name, " addr"},    33'(addr),    33'd0);
  endtask

  // ---------------- scan/print responder ----------------
  initial begin : responder
    int          wcnt;
    logic [32:0] r;
    wcnt = 0;
    ack_tx = 1'b0; ack_rx = 1'b0; flag_rx = 1'b0; din_rx = '0;
    forever begin
      @(posedge clk); #1;
      ack_tx = 1'b0;
      ack_rx = 1'b0;
      if (!rstn) wcnt = 0;
      if (req_tx) begin
        if (wcnt >= tx_delay) begin
          ack_tx = 1'b1;
          wcnt   = 0;
        end else begin
          wcnt++;
        end
      end
      if (spur_rx) begin
        ack_rx  = 1'b1;
        flag_rx = 1'b1;
        din_rx  = 32'h99;
        spur_rx = 1'b0;
      end else if (req_rx && rx_q.size() > 0) begin
        r       = rx_q.pop_front();
        ack_rx  = 1'b1;
        flag_rx = r[32];
        din_rx  = r[31:0];
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial begin : compare
    logic        p_req, p_ack, p_type, p_act;
    logic [31:0] p_dout;
    logic [32:0] e;
    p_req = 1'b0; p_ack = 1'b0; p_type = 1'b0; p_act = 1'b0; p_dout = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        p_req = 1'b0;
        p_ack = 1'b0;
      end else begin
        if (p_act && p_req && !p_ack) begin
          check("tx req held", 33'(req_tx), 33'd1);
          check("tx payload held", {type_tx, dout_tx}, {p_type, p_dout});
        end
        if (p_req && p_ack) check("tx req drop after ack", 33'(req_tx), 33'd0);
        if (req_tx && ack_tx) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx unexpected print: actual %h required none", {type_tx, dout_tx});
          end else begin
            e = exp_q.pop_front();
            check("tx print", {type_tx, dout_tx}, e);
          end
        end
        if (req_rx && ack_rx) check("rx type", 33'(type_rx), 33'd1);
        p_req  = req_tx;
        p_ack  = ack_tx;
        p_type = type_tx;
        p_dout = dout_tx;
        p_act  = (sel_mode != 8'h00);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [32:0] lit [8];
    rstn = 1'b0;
    sel_mode = 8'h00;
    mdl_next[0] = 8'h00;
    mdl_next[1] = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // D 10 2
    start_cmd(1'b0, 1'b1, 32'h10, 1'b1, 32'h2);
    lit = '{hx(32'h10), ch(32'h2D), hx(32'h110), ch(32'h0A),
            hx(32'h11), ch(32'h2D), hx(32'h111), ch(32'h0A)};
    check("pin d10 size", 33'(exp_q.size()), 33'd8);
    for (int i = 0; i < 8; i++) check("pin d10 token", exp_q[i], lit[i]);
    wait_done("d10");

    // bare D resumes at 0x12 with the default 8 words
    start_cmd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("pin bare d size", 33'(exp_q.size()), 33'd32);
    check("pin bare d first", exp_q[0], hx(32'h12));
    check("pin bare d last", exp_q[28], hx(32'h19));
    check("pin bare d last data", exp_q[30], hx(32'h119));
    wait_done("bare d");

    // bare I has its own pointer, starting at 0
    start_cmd(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("pin bare i first", exp_q[0], hx(32'h0));
    check("pin bare i data", exp_q[2], hx(32'h200));
    wait_done("bare i");

    start_cmd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("pin bare d again", exp_q[0], hx(32'h1A));
    wait_done("bare d again");

    // wrap: upper din bits ignored, count from din[7:0]=3
    start_cmd(1'b0, 1'b1, 32'hABCD_00FE, 1'b1, 32'h103);
    check("pin wrap size", 33'(exp_q.size()), 33'd12);
    check("pin wrap w0", exp_q[0], hx(32'hFE));
    check("pin wrap w1", exp_q[4], hx(32'hFF));
    check("pin wrap w2", exp_q[8], hx(32'h00));
    check("pin wrap w2 data", exp_q[10], hx(32'h100));
    wait_done("wrap");

    // explicit zero count falls back to the default
    start_cmd(1'b0, 1'b1, 32'h60, 1'b1, 32'h100);
    check("pin zero count size", 33'(exp_q.size()), 33'd32);
    wait_done("zero count");

    // slow print ack, plus a stray scan ack during the separator
    tx_delay = 50;
    start_cmd(1'b0, 1'b1, 32'h40, 1'b1, 32'h1);
    wait_print("slow sep", ch(32'h2D));
    spur_rx = 1'b1;
    wait_done("slow");
    tx_delay = 0;

    // abort during the second word's data
    tx_delay = 3;
    start_cmd(1'b0, 1'b1, 32'h30, 1'b1, 32'h4);
    wait_print("abort data", hx(32'h131));
    @(posedge clk); #1;
    sel_mode = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("abort req_tx", 33'(req_tx), 33'd0);
    check("abort req_rx", 33'(req_rx), 33'd0);
    check("abort finish", 33'(finish), 33'd0);
    exp_q.delete();
    rx_q.delete();
    mdl_next[0] = 8'h31;
    tx_delay = 0;
    start_cmd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("pin resume first", exp_q[0], hx(32'h31));
    wait_done("resume");

    // asynchronous reset while printing the address
    tx_delay = 10;
    start_cmd(1'b0, 1'b1, 32'h50, 1'b1, 32'h2);
    wait_print("reset addr", hx(32'h50));
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    check_all_zero("mid reset");
    exp_q.delete();
    rx_q.delete();
    mdl_next[0] = 8'h00;
    mdl_next[1] = 8'h00;
    sel_mode = 8'h00;
    tx_delay = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    start_cmd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("pin post reset d", exp_q[0], hx(32'h0));
    wait_done("post reset d");
    start_cmd(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    wait_done("post reset i");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
